// File: rtl/even_check_arbiter_pkg.sv
// Shared types and helpers for the even_check_arbiter slice.
package even_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/even_check_arbiter_if.sv
// Request/response/statistics bundle between clients and the shared even checker.
interface even_check_if
  import even_pkg::*;
#(
  parameter int unsigned NUM_SIZE = 12,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*NUM_SIZE-1:0] req_num;
  logic [N_REQ-1:0]          req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [NUM_SIZE-1:0]       resp_num;
  logic                      resp_even;
  logic                      clr_cnt;
  logic [CNT_W-1:0]          even_cnt;
  logic [CNT_W-1:0]          odd_cnt;

  modport master (
    output req_valid, req_num, resp_ready, clr_cnt,
    input  req_ready, resp_valid, resp_id, resp_num, resp_even, even_cnt, odd_cnt
  );

  modport slave (
    input  req_valid, req_num, resp_ready, clr_cnt,
    output req_ready, resp_valid, resp_id, resp_num, resp_even, even_cnt, odd_cnt
  );
endinterface

// File: rtl/even_check_arbiter_is_even.sv
// Parity checker: a number is even when its LSB is clear.
module is_even #(
  parameter int unsigned NUM_SIZE = 12
) (
  input  logic [NUM_SIZE-1:0] num,
  output logic                even
);
  logic w_unused_hi;

  assign even        = ~num[0];
  assign w_unused_hi = ^num[NUM_SIZE-1:1];
endmodule

// File: rtl/even_check_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = IW'((32'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/even_check_arbiter.sv
// Shares one is_even checker among N_REQ requesters with round-robin grant,
// a tagged valid/ready response port and saturating even/odd counters.
module even_check_arbiter
  import even_pkg::*;
#(
  parameter int unsigned NUM_SIZE = 12,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  even_check_if.slave bus
);
  localparam int unsigned ID_W = id_w(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id_q;
  logic [NUM_SIZE-1:0] r_num_q;
  logic                r_resp_valid;
  logic [ID_W-1:0]     r_resp_id;
  logic [NUM_SIZE-1:0] r_resp_num;
  logic                r_resp_even;
  logic [CNT_W-1:0]    r_even_cnt;
  logic [CNT_W-1:0]    r_odd_cnt;

  logic [N_REQ-1:0]    w_grant;
  logic [N_REQ-1:0]    w_req_ready;
  logic [ID_W-1:0]     w_grant_id;
  logic [NUM_SIZE-1:0] w_sel_num;
  logic                w_even;
  logic                w_accept;
  logic                w_hs;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  is_even #(.NUM_SIZE(NUM_SIZE)) u_is_even (
    .num  (r_num_q),
    .even (w_even)
  );

  // One-hot grant to index plus the granted requester's number.
  always_comb begin
    w_grant_id = '0;
    w_sel_num  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_id = ID_W'(i);
        w_sel_num  = bus.req_num[i*NUM_SIZE +: NUM_SIZE];
      end
    end
  end

  assign w_accept = (r_state == IDLE) && (|bus.req_valid);
  assign w_hs     = (r_state == RESP) && bus.resp_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      IDLE: begin
        w_req_ready = w_grant;
        if (|bus.req_valid) w_state_nxt = CHECK;
      end
      CHECK:   w_state_nxt = RESP;
      RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_num_q      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_num   <= '0;
      r_resp_even  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_num_q <= w_sel_num;
        r_id_q  <= w_grant_id;
      end
      if (r_state == CHECK) begin
        r_resp_num   <= r_num_q;
        r_resp_id    <= r_id_q;
        r_resp_even  <= w_even;
        r_resp_valid <= 1'b1;
      end
      if (w_hs) begin
        r_resp_valid <= 1'b0;
        r_rr_ptr     <= ID_W'((32'(r_id_q) + 32'd1) % N_REQ);
      end
    end
  end

  // Statistics: clear wins over a same-cycle handshake; no wrap at the top.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_cnt) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (w_hs) begin
      if (r_resp_even) begin
        if (r_even_cnt != CNT_MAX) r_even_cnt <= r_even_cnt + CNT_W'(1);
      end else begin
        if (r_odd_cnt != CNT_MAX) r_odd_cnt <= r_odd_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_num   = r_resp_num;
  assign bus.resp_even  = r_resp_even;
  assign bus.even_cnt   = r_even_cnt;
  assign bus.odd_cnt    = r_odd_cnt;
endmodule

// File: tb/tb_even_check_arbiter.sv
// Directed bench for even_check_arbiter: a 16-bit-counter instance and a 2-bit one for saturation.
module tb_even_check_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  even_check_if #(.NUM_SIZE(12), .N_REQ(4), .CNT_W(16)) if_m ();
  even_check_if #(.NUM_SIZE(12), .N_REQ(4), .CNT_W(2))  if_s ();

  even_check_arbiter #(.NUM_SIZE(12), .N_REQ(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  even_check_arbiter #(.NUM_SIZE(12), .N_REQ(4), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sat_txn(input logic [11:0] n, input logic clr);
    if_s.req_valid  = 4'b0001;
    if_s.req_num    = {36'd0, n};
    if_s.resp_ready = 1'b1;
    tick();
    if_s.req_valid = 4'b0000;
    tick();
    if_s.clr_cnt = clr;
    tick();
    if_s.clr_cnt    = 1'b0;
    if_s.resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] nums [4];
    logic [3:0]  mask;
    int          g;
    int          ptr_m;
    int          exp_even;
    int          exp_odd;
    int          stall;

    rst_n = 1'b0;
    if_m.req_valid = '0; if_m.req_num = '0; if_m.resp_ready = 1'b0; if_m.clr_cnt = 1'b0;
    if_s.req_valid = '0; if_s.req_num = '0; if_s.resp_ready = 1'b0; if_s.clr_cnt = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_resp_valid", 32'(if_m.resp_valid), 32'd0);
    check("rst_resp_id",    32'(if_m.resp_id),    32'd0);
    check("rst_resp_num",   32'(if_m.resp_num),   32'd0);
    check("rst_resp_even",  32'(if_m.resp_even),  32'd0);
    check("rst_even_cnt",   32'(if_m.even_cnt),   32'd0);
    check("rst_odd_cnt",    32'(if_m.odd_cnt),    32'd0);
    check("rst_req_ready",  32'(if_m.req_ready),  32'd0);
    rst_n = 1'b1;

    // 1. Single request, number 6
    if_m.req_valid = 4'b0001;
    if_m.req_num   = 48'd6;
    #1;
    check("t1_req_ready", 32'(if_m.req_ready), 32'h1);
    tick();
    if_m.req_valid = 4'b0000;
    #1;
    check("t1_check_ready", 32'(if_m.req_ready),  32'h0);
    check("t1_check_valid", 32'(if_m.resp_valid), 32'd0);
    tick();
    check("t1_resp_valid", 32'(if_m.resp_valid), 32'd1);
    check("t1_resp_id",    32'(if_m.resp_id),    32'd0);
    check("t1_resp_num",   32'(if_m.resp_num),   32'd6);
    check("t1_resp_even",  32'(if_m.resp_even),  32'd1);
    if_m.resp_ready = 1'b1;
    tick();
    if_m.resp_ready = 1'b0;
    check("t1_valid_drop", 32'(if_m.resp_valid), 32'd0);
    check("t1_even_cnt",   32'(if_m.even_cnt),   32'd1);

    // 2. All requesting, odd numbers, resp_ready tied high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_m.req_valid  = 4'b1111;
    if_m.req_num    = {12'd9, 12'd7, 12'd5, 12'd3};
    if_m.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t2_grant", 32'(if_m.req_ready), 32'(1 << (k % 4)));
      if (k == 4) check("t2_odd_cnt4", 32'(if_m.odd_cnt), 32'd4);
      tick();
      check("t2_check_valid", 32'(if_m.resp_valid), 32'd0);
      tick();
      check("t2_resp_valid", 32'(if_m.resp_valid), 32'd1);
      check("t2_resp_id",    32'(if_m.resp_id),    32'(k % 4));
      check("t2_resp_num",   32'(if_m.resp_num),   32'(3 + 2 * (k % 4)));
      check("t2_resp_even",  32'(if_m.resp_even),  32'd0);
      tick();
    end
    if_m.req_valid  = 4'b0000;
    if_m.resp_ready = 1'b0;
    #1;
    check("t2_odd_cnt5", 32'(if_m.odd_cnt), 32'd5);

    // 3. Backpressure on an all-ones number (ptr now 1)
    if_m.req_valid = 4'b0100;
    if_m.req_num   = {12'd0, 12'hFFF, 12'd0, 12'd0};
    #1;
    check("t3_grant", 32'(if_m.req_ready), 32'h4);
    tick();
    if_m.req_valid = 4'b1011;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_valid", 32'(if_m.resp_valid), 32'd1);
      check("t3_stall_num",   32'(if_m.resp_num),   32'hFFF);
      check("t3_stall_id",    32'(if_m.resp_id),    32'd2);
      check("t3_stall_even",  32'(if_m.resp_even),  32'd0);
      check("t3_stall_ready", 32'(if_m.req_ready),  32'd0);
      check("t3_stall_odd",   32'(if_m.odd_cnt),    32'd5);
      tick();
    end
    if_m.req_valid  = 4'b0000;
    if_m.resp_ready = 1'b1;
    tick();
    if_m.resp_ready = 1'b0;
    check("t3_valid_drop", 32'(if_m.resp_valid), 32'd0);
    check("t3_odd_cnt",    32'(if_m.odd_cnt),    32'd6);

    // 4. Saturation on the 2-bit-counter instance, then clear during a handshake
    sat_txn(12'd2, 1'b0);
    sat_txn(12'd4, 1'b0);
    sat_txn(12'd6, 1'b0);
    check("t4_even_3", 32'(if_s.even_cnt), 32'd3);
    sat_txn(12'd8, 1'b0);
    sat_txn(12'd10, 1'b0);
    check("t4_even_sat", 32'(if_s.even_cnt), 32'd3);
    sat_txn(12'd11, 1'b0);
    check("t4_odd_1",  32'(if_s.odd_cnt),  32'd1);
    check("t4_even_h", 32'(if_s.even_cnt), 32'd3);
    sat_txn(12'd13, 1'b1);
    check("t4_clr_even", 32'(if_s.even_cnt), 32'd0);
    check("t4_clr_odd",  32'(if_s.odd_cnt),  32'd0);

    // 5. Reset during CHECK (ptr is 3 before the reset)
    if_m.req_valid = 4'b0010;
    if_m.req_num   = {12'd0, 12'd0, 12'd8, 12'd0};
    #1;
    check("t5_grant1", 32'(if_m.req_ready), 32'h2);
    tick();
    rst_n = 1'b0;
    if_m.req_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    check("t5_rst_valid", 32'(if_m.resp_valid), 32'd0);
    check("t5_rst_even",  32'(if_m.even_cnt),   32'd0);
    check("t5_rst_odd",   32'(if_m.odd_cnt),    32'd0);
    for (int c = 0; c < 3; c++) begin
      check("t5_no_resp", 32'(if_m.resp_valid), 32'd0);
      tick();
    end
    if_m.req_valid = 4'b1001;
    if_m.req_num   = {12'd10, 12'd0, 12'd0, 12'd1};
    #1;
    check("t5_ptr_zero", 32'(if_m.req_ready), 32'h1);
    if_m.req_valid = 4'b1000;
    #1;
    check("t5_grant3", 32'(if_m.req_ready), 32'h8);
    if_m.resp_ready = 1'b1;
    tick();
    if_m.req_valid = 4'b0000;
    tick();
    check("t5_resp_id",   32'(if_m.resp_id),   32'd3);
    check("t5_resp_num",  32'(if_m.resp_num),  32'd10);
    check("t5_resp_even", 32'(if_m.resp_even), 32'd1);
    tick();
    if_m.resp_ready = 1'b0;
    check("t5_valid_drop", 32'(if_m.resp_valid), 32'd0);
    check("t5_even_cnt",   32'(if_m.even_cnt),   32'd1);

    // 6. Random numbers over random requester sets
    ptr_m    = 0;
    exp_even = 1;
    exp_odd  = 0;
    for (int t = 0; t < 50; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) begin
        nums[r] = 12'($urandom);
        if_m.req_num[r*12 +: 12] = nums[r];
      end
      if_m.req_valid = mask;
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && mask[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
      #1;
      check("t6_grant", 32'(if_m.req_ready), 32'(1 << g));
      tick();
      if_m.req_valid = 4'b0000;
      tick();
      stall = int'($urandom_range(0, 2));
      for (int c = 0; c < stall; c++) begin
        check("t6_stall_valid", 32'(if_m.resp_valid), 32'd1);
        tick();
      end
      check("t6_resp_valid", 32'(if_m.resp_valid), 32'd1);
      check("t6_resp_id",    32'(if_m.resp_id),    32'(g));
      check("t6_resp_num",   32'(if_m.resp_num),   32'(nums[g]));
      check("t6_resp_even",  32'(if_m.resp_even),  32'((nums[g] % 2) == 0));
      if_m.resp_ready = 1'b1;
      tick();
      if_m.resp_ready = 1'b0;
      if ((nums[g] % 2) == 0) exp_even++; else exp_odd++;
      ptr_m = (g + 1) % 4;
      check("t6_once",     32'(if_m.resp_valid), 32'd0);
      check("t6_even_cnt", 32'(if_m.even_cnt),   32'(exp_even));
      check("t6_odd_cnt",  32'(if_m.odd_cnt),    32'(exp_odd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
